// File: rtl/pipe_ctrl_pkg.sv
// Shared state encoding and control bundle for the pipeline hold/flush controller.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    PC_RUN      = 2'd0,
    PC_BUBBLE   = 2'd1,
    PC_STALL_EX = 2'd2,
    PC_WAIT_BUS = 2'd3
  } pc_state_e;

  typedef struct packed {
    logic pc_hold;
    logic pc_load;
    logic if_id_hold;
    logic if_id_flush;
    logic id_ex_hold;
    logic id_ex_flush;
  } pipe_ctl_t;

endpackage

// File: rtl/pipe_ctrl_bus_watchdog.sv
// Counts consecutive bus-wait cycles, saturating at BUS_TIMEOUT; emits one registered
// pulse per wait episode, the cycle after the count first reaches the limit.
module bus_watchdog #(
  parameter int unsigned BUS_TIMEOUT = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic wait_i,
  output logic timeout_o
);

  localparam int unsigned CW = $clog2(BUS_TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(BUS_TIMEOUT);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          pulse_q, pulse_d;

  always_comb begin
    cnt_d   = '0;
    pulse_d = 1'b0;
    if (wait_i) begin
      if (cnt_q != LIMIT) begin
        cnt_d   = cnt_q + 1'b1;
        pulse_d = (cnt_q == LIMIT - 1'b1);
      end else begin
        cnt_d = cnt_q;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  assign timeout_o = pulse_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Hold/flush/redirect controller for the PC, IF/ID and ID/EX registers.
// Priority: bus wait > jump > EX busy > load-use; jumps arriving during a bus wait are parked.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned BUS_TIMEOUT = 16
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        jump_en,
  input  logic [31:0] jump_addr,
  input  logic        hold_req_bus,
  input  logic        hold_req_ex,
  input  logic        load_use,
  output logic        pc_hold,
  output logic        pc_load,
  output logic [31:0] pc_load_addr,
  output logic        if_id_hold,
  output logic        if_id_flush,
  output logic        id_ex_hold,
  output logic        id_ex_flush,
  output logic [1:0]  state,
  output logic        bus_timeout,
  output logic [31:0] stall_cnt
);

  pc_state_e   state_q, state_d;
  logic        pend_valid_q, pend_valid_d;
  logic [31:0] pend_addr_q, pend_addr_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;
  pipe_ctl_t   ctl;
  logic [31:0] load_addr;
  logic        bus_wait;

  always_comb begin
    ctl          = '0;
    load_addr    = '0;
    state_d      = PC_RUN;
    pend_valid_d = pend_valid_q;
    pend_addr_d  = pend_addr_q;
    if (sys_rst) begin
      state_d = PC_RUN;
    end else if (hold_req_bus) begin
      ctl.pc_hold    = 1'b1;
      ctl.if_id_hold = 1'b1;
      ctl.id_ex_hold = 1'b1;
      state_d        = PC_WAIT_BUS;
      if (jump_en && !pend_valid_q) begin
        pend_valid_d = 1'b1;
        pend_addr_d  = jump_addr;
      end
    end else if (state_q == PC_WAIT_BUS && pend_valid_q) begin
      // Replay the parked redirect; a jump arriving this cycle is dropped.
      ctl.pc_load     = 1'b1;
      ctl.if_id_flush = 1'b1;
      ctl.id_ex_flush = 1'b1;
      load_addr       = pend_addr_q;
      pend_valid_d    = 1'b0;
    end else if (jump_en) begin
      ctl.pc_load     = 1'b1;
      ctl.if_id_flush = 1'b1;
      ctl.id_ex_flush = 1'b1;
      load_addr       = jump_addr;
    end else if (hold_req_ex) begin
      ctl.pc_hold    = 1'b1;
      ctl.if_id_hold = 1'b1;
      ctl.id_ex_hold = 1'b1;
      state_d        = PC_STALL_EX;
    end else if (load_use && state_q != PC_BUBBLE) begin
      ctl.pc_hold     = 1'b1;
      ctl.if_id_hold  = 1'b1;
      ctl.id_ex_flush = 1'b1;
      state_d         = PC_BUBBLE;
    end
  end

  assign stall_cnt_d = stall_cnt_q + {31'd0, ctl.pc_hold};
  assign bus_wait    = (state_q == PC_WAIT_BUS) && hold_req_bus && !sys_rst;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q      <= PC_RUN;
      pend_valid_q <= 1'b0;
      pend_addr_q  <= '0;
      stall_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      pend_valid_q <= pend_valid_d;
      pend_addr_q  <= pend_addr_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  bus_watchdog #(
    .BUS_TIMEOUT(BUS_TIMEOUT)
  ) u_bus_watchdog (
    .clk_i    (sys_clk),
    .rst_i    (sys_rst),
    .wait_i   (bus_wait),
    .timeout_o(bus_timeout)
  );

  assign pc_hold      = ctl.pc_hold;
  assign pc_load      = ctl.pc_load;
  assign pc_load_addr = load_addr;
  assign if_id_hold   = ctl.if_id_hold;
  assign if_id_flush  = ctl.if_id_flush;
  assign id_ex_hold   = ctl.id_ex_hold;
  assign id_ex_flush  = ctl.id_ex_flush;
  assign state        = state_q;
  assign stall_cnt    = stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench: each driven cycle pushes the reference model's expected outputs;
// a negedge monitor pops and compares.
module tb_pipe_ctrl;

  localparam int TMO = 16;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        jump_en = 1'b0;
  logic [31:0] jump_addr = '0;
  logic        hold_req_bus = 1'b0;
  logic        hold_req_ex = 1'b0;
  logic        load_use = 1'b0;
  logic        pc_hold, pc_load, if_id_hold, if_id_flush, id_ex_hold, id_ex_flush;
  logic [31:0] pc_load_addr, stall_cnt;
  logic [1:0]  state;
  logic        bus_timeout;

  pipe_ctrl #(.BUS_TIMEOUT(TMO)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .jump_en(jump_en), .jump_addr(jump_addr),
    .hold_req_bus(hold_req_bus), .hold_req_ex(hold_req_ex), .load_use(load_use),
    .pc_hold(pc_hold), .pc_load(pc_load), .pc_load_addr(pc_load_addr),
    .if_id_hold(if_id_hold), .if_id_flush(if_id_flush), .id_ex_hold(id_ex_hold),
    .id_ex_flush(id_ex_flush), .state(state), .bus_timeout(bus_timeout), .stall_cnt(stall_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct packed {
    logic [5:0]  ctl;
    logic [31:0] addr;
    logic [1:0]  st;
    logic        to;
    logic [31:0] stall;
  } exp_t;

  exp_t sb[$];
  int   nchecks = 0;
  int   nerrors = 0;

  // Reference model: "mode" is what the controller did last cycle, parked jumps live in a queue.
  int          m_mode = 0;
  logic [31:0] m_parked[$];
  int          m_wait = 0;
  bit          m_pulse = 1'b0;
  logic [31:0] m_stall = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input bit r, input bit j, input logic [31:0] ja,
                       input bit b, input bit x, input bit l);
    exp_t e;
    bit ph, pl, ih, ifl, eh, efl;
    logic [31:0] la;
    int nxt;
    @(posedge sys_clk); #1;
    sys_rst = r; jump_en = j; jump_addr = ja; hold_req_bus = b; hold_req_ex = x; load_use = l;
    {ph, pl, ih, ifl, eh, efl} = '0;
    la = '0;
    nxt = 0;
    e.st = 2'(m_mode);
    e.to = m_pulse;
    e.stall = m_stall;
    if (r) begin
      m_mode = 0; m_parked.delete(); m_wait = 0; m_pulse = 0; m_stall = '0;
    end else begin
      if (b) begin
        {ph, ih, eh} = 3'b111; nxt = 3;
        if (j && m_parked.size() == 0) m_parked.push_back(ja);
      end else if (m_mode == 3 && m_parked.size() != 0) begin
        pl = 1; ifl = 1; efl = 1; la = m_parked.pop_front();
      end else if (j) begin
        pl = 1; ifl = 1; efl = 1; la = ja;
      end else if (x) begin
        {ph, ih, eh} = 3'b111; nxt = 2;
      end else if (l && m_mode != 1) begin
        ph = 1; ih = 1; efl = 1; nxt = 1;
      end
      if (m_mode == 3 && b) begin
        m_pulse = (m_wait == TMO - 1);
        if (m_wait < TMO) m_wait++;
      end else begin
        m_wait = 0; m_pulse = 0;
      end
      m_stall = m_stall + 32'(ph);
      m_mode = nxt;
    end
    e.ctl = {ph, pl, ih, ifl, eh, efl};
    e.addr = la;
    sb.push_back(e);
    @(negedge sys_clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 32'd0, 0, 0, 0);
  endtask

  task automatic do_reset();
    drive(1, 0, 32'd0, 0, 0, 0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge sys_clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("ctl", 32'({pc_hold, pc_load, if_id_hold, if_id_flush, id_ex_hold, id_ex_flush}), 32'(e.ctl));
        chk("pc_load_addr", pc_load_addr, e.addr);
        chk("state", 32'(state), 32'(e.st));
        chk("bus_timeout", 32'(bus_timeout), 32'(e.to));
        chk("stall_cnt", stall_cnt, e.stall);
      end
    end
  end

  initial begin : stim
    int pulses, pulse_at;
    bit b;
    do_reset();
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_stall", stall_cnt, 32'd0);

    drive(0, 1, 32'h100, 0, 0, 0);
    chk("jump_load", 32'({pc_load, if_id_flush, id_ex_flush}), 32'h7);
    chk("jump_addr", pc_load_addr, 32'h100);
    chk("jump_state", 32'(state), 32'd0);

    do_reset();
    drive(0, 0, 32'd0, 0, 0, 1);
    chk("lu_c1", 32'({pc_hold, if_id_hold, id_ex_flush}), 32'h7);
    drive(0, 0, 32'd0, 0, 0, 1);
    chk("lu_c2_state", 32'(state), 32'd1);
    chk("lu_c2_ctl", 32'({pc_hold, if_id_hold, id_ex_flush}), 32'h0);
    chk("lu_c2_stall", stall_cnt, 32'd1);

    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, 32'h200, 1, 0, 0);
      chk("park_hold", 32'({pc_hold, if_id_hold, id_ex_hold, if_id_flush, id_ex_flush}), 32'h1C);
    end
    drive(0, 1, 32'h999, 0, 0, 0);
    chk("park_release_addr", pc_load_addr, 32'h200);
    chk("park_release_flush", 32'({pc_load, if_id_flush, id_ex_flush}), 32'h7);
    drive(0, 0, 32'd0, 0, 0, 0);
    chk("park_after_state", 32'(state), 32'd0);
    chk("park_after_stall", stall_cnt, 32'd5);

    do_reset();
    drive(0, 0, 32'd0, 0, 1, 0);
    chk("exbus_c1_hold", 32'(pc_hold), 32'd1);
    drive(0, 0, 32'd0, 1, 1, 0);
    chk("exbus_c2_state", 32'(state), 32'd2);
    drive(0, 0, 32'd0, 0, 1, 0);
    chk("exbus_c3_state", 32'(state), 32'd3);
    chk("exbus_c3_hold", 32'(pc_hold), 32'd1);
    drive(0, 0, 32'd0, 0, 0, 0);
    chk("exbus_c4_state", 32'(state), 32'd2);
    drive(0, 0, 32'd0, 0, 0, 0);
    chk("exbus_c5_state", 32'(state), 32'd0);

    do_reset();
    pulses = 0; pulse_at = 0;
    for (int i = 1; i <= 20; i++) begin
      drive(0, 0, 32'd0, 1, 0, 0);
      if (bus_timeout) begin pulses++; pulse_at = i; end
    end
    chk("tmo_pulses", 32'(pulses), 32'd1);
    chk("tmo_cycle", 32'(pulse_at), 32'd18);
    chk("tmo_still_held", 32'(pc_hold), 32'd1);
    idle(2);

    do_reset();
    for (int i = 0; i < 3; i++) drive(0, 1, 32'h300, 1, 0, 0);
    do_reset();
    drive(0, 0, 32'd0, 0, 0, 0);
    chk("rstmid_state", 32'(state), 32'd0);
    chk("rstmid_stall", stall_cnt, 32'd0);
    chk("rstmid_noload", 32'(pc_load), 32'd0);
    idle(3);

    b = 0;
    for (int i = 0; i < 3000; i++) begin
      b = b ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 7) == 0);
      drive($urandom_range(0, 149) == 0, $urandom_range(0, 5) == 0, $urandom,
            b, $urandom_range(0, 4) == 0, $urandom_range(0, 3) == 0);
    end
    idle(2);
    @(negedge sys_clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
